usb_tx_serializer: RTL and testbench
====================================

# usb_tx_serializer

Full-speed USB transmit serializer: accepts packet bytes over a valid/ready byte stream and drives the D+/D- pair. Prepends SYNC, bit-stuffs, NRZI-encodes and appends EOP. Transmit-direction counterpart of the receive path in the transceiver; sits between the packet/CRC layer and the bus driver.

## Interface
- CLKS_PER_BIT, 4: clock cycles per USB bit period, 2 or more.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  8  packet byte, sent LSB first.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  current byte is final byte of packet.
- tx_ready  out  1  byte is taken at this edge if tx_valid=1.
- dp_out  out  1  D+ line, registered.
- dm_out  out  1  D- line, registered.
- tx_active  out  1  packet on the line, SYNC through EOP.
- tx_underrun  out  1  one-cycle pulse: byte missing mid-packet.

## Operation
- Line states: J = (dp=1, dm=0), K = (0,1), SE0 = (0,0). Idle line is J.
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- IDLE: tx_ready=1. A handshake (tx_valid & tx_ready at an edge) captures tx_data/tx_last into the hold register. It also enters SYNC and drives the first SYNC bit.
- SYNC: byte 8'h80 sent LSB first (seven 0s then a 1). Then DATA with the held byte.
- NRZI: a 0 bit toggles the line; a 1 bit holds it.
- Bit stuffing: a consecutive-ones counter spans SYNC and DATA and includes SYNC's final 1. After six consecutive 1s, one 0 bit is inserted and the counter clears. A data 0 also clears the counter. A stuff bit due after the last data bit is sent before EOP.
- Byte fetch: tx_ready depends only on internal state, never on tx_valid. In SYNC/DATA it is high during the last clock of the final bit period of the current byte. That final bit period includes any pending stuff bit.
  - Handshake at that edge: the next byte loads seamlessly.
  - If the current byte has tx_last=1: tx_ready stays low and the block goes to EOP_SE0.
  - If tx_last=0 and tx_valid=0 at that edge: pulse tx_underrun and go to EOP_SE0 (truncated packet).
- EOP_SE0 lasts 2 bit periods; EOP_J lasts 1 bit period. Then IDLE.
- tx_data/tx_last are ignored except at handshake edges.

## Timing
- Reset values: dp_out=1, dm_out=0, tx_active=0, tx_underrun=0. tx_ready=1 (IDLE). Ones counter=0. Bit timer=0.
- Reset mid-packet: outputs return to reset values immediately and asynchronously. The packet is abandoned with no EOP. The next packet starts clean.
- Latency: the first SYNC bit (K) and tx_active=1 appear after the IDLE handshake edge.
- Every bit, including stuff bits, lasts exactly CLKS_PER_BIT cycles. The line changes only at bit boundaries.
- tx_active falls at the edge ending EOP_J, with the line at J. A new IDLE handshake is possible at that same edge's following cycle; there is no back-to-back overlap.
- Packet length in bit periods: 8 + 8*bytes + stuff bits + 3.

## Structure
- Package usb_tx_pkg:
  - state enum
  - SYNC_BYTE = 8'h80
  - STUFF_LIMIT = 6
  - EOP_SE0_BITS = 2
  - line-state constants J, K, SE0
- Sub-module usb_tx_bit_timer: counts 0..CLKS_PER_BIT-1 while the packet is active and emits bit_end on the final count. It clears in IDLE and on rst.
- Top level holds the FSM, shift register, bit index, ones counter and the NRZI output register.

## Test plan
- Reset asserted mid-idle -> dp=1, dm=0, tx_active=0, tx_ready=1, tx_underrun=0.
- Single byte 0x00, tx_last=1, CLKS_PER_BIT=4 -> line KJKJKJKK, JKJKJKJK, SE0, SE0, J. That is 19 bit periods (76 cycles) of tx_active. tx_ready is high only in the IDLE cycle.
- Bytes 0xFF, 0xFF (last) -> stuffed 0 after byte1 bit 5 and after byte2 bit 3. Total 29 bit periods (116 cycles). Second tx_ready occurs at the end of byte1 bit 8.
- Byte 0xFC, tx_last=1 -> six trailing 1s. The stuffed toggle precedes SE0. Total 20 bit periods.
- Two-byte stream, tx_valid low at byte1 fetch with tx_last=0 -> tx_underrun pulses one cycle. SE0 directly follows byte1 bit 8. tx_active falls 3 bit periods later.
- rst pulsed during DATA byte 2 -> same-cycle dp=1, dm=0, tx_active=0. A following 0x00 packet matches the single-byte trace exactly, with no stale stuff count.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the full-speed USB transmit serializer: FSM states,
// protocol constants, line-state encodings and the NRZI helper.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_SE0,
      EOP_J
   } TxState;

   localparam logic [7:0] SYNC_BYTE    = 8'h80;
   localparam int         STUFF_LIMIT  = 6;
   localparam int         EOP_SE0_BITS = 2;

   // Line states are packed as {dp, dm}
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;

   // NRZI: a 0 bit flips J<->K, a 1 bit leaves the line where it is
   function automatic logic [1:0] nrziNext(input logic [1:0] line, input logic dataBit);
      return dataBit ? line : ~line;
   endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: divides the system clock into USB bit periods and flags
// the last clock of each period so the serializer knows when to launch the
// next bit.
module usb_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   output logic bitEnd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Free-run through one bit period at a time while a packet is on the line;
   // hold at zero when idle so the first bit after a handshake gets a full period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!active) begin
         count <= '0;
      end else if (count == LAST_COUNT) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // The period boundary is the final count, but only while actually sending
   always_comb begin
      bitEnd = active && (count == LAST_COUNT);
   end

endmodule

// File: rtl/usb_tx_serializer.sv
// Full-speed USB transmit serializer. Takes packet bytes over a valid/ready
// stream, prepends SYNC, bit-stuffs, NRZI-encodes and finishes with an EOP.
module usb_tx_serializer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       dp_out,
   output logic       dm_out,
   output logic       tx_active,
   output logic       tx_underrun
);

   TxState     state;
   logic [7:0] shiftReg;
   logic [7:0] holdData;
   logic       holdLast;
   logic [2:0] bitIdx;
   logic [2:0] onesCount;
   logic       stuffPending;
   logic [1:0] eopCount;
   logic [1:0] lineState;
   logic       txActiveReg;
   logic       underrunReg;

   logic       bitEnd;
   logic       byteEnd;
   logic       launchBit;
   logic [2:0] onesNext;

   usb_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) bitTimer (
      .clk   (clk),
      .rst   (rst),
      .active(state != IDLE),
      .bitEnd(bitEnd)
   );

   // Work out what happens at the next bit boundary: whether the current byte
   // (including any owed stuff bit) is finished, which data bit goes out next,
   // and what the run-of-ones count becomes once that bit is on the line.
   // tx_ready is derived from state only so the upstream side never sees a
   // combinational path from its own tx_valid.
   always_comb begin
      byteEnd   = bitEnd && (bitIdx == 3'd7) && !stuffPending;
      launchBit = shiftReg[1];
      if (bitIdx == 3'd7) begin
         launchBit = (state == SYNC) ? holdData[0] : tx_data[0];
      end
      onesNext = launchBit ? (onesCount + 3'd1) : 3'd0;
      tx_ready = (state == IDLE) || ((state == DATA) && byteEnd && !holdLast);
   end

   // Main packet FSM. Every line change happens either at the IDLE handshake
   // (first SYNC bit) or at a bit boundary, so bits, stuff bits and EOP
   // periods all last exactly one timer period. A stuff bit is sent at the
   // boundary after the sixth 1 and keeps the byte open, which is why the
   // byte only ends once nothing is pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         shiftReg     <= '0;
         holdData     <= '0;
         holdLast     <= 1'b0;
         bitIdx       <= '0;
         onesCount    <= '0;
         stuffPending <= 1'b0;
         eopCount     <= '0;
         lineState    <= J;
         txActiveReg  <= 1'b0;
         underrunReg  <= 1'b0;
      end else begin
         underrunReg <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  holdData     <= tx_data;
                  holdLast     <= tx_last;
                  shiftReg     <= SYNC_BYTE;
                  bitIdx       <= '0;
                  onesCount    <= '0;
                  stuffPending <= 1'b0;
                  lineState    <= nrziNext(J, SYNC_BYTE[0]);
                  txActiveReg  <= 1'b1;
                  state        <= SYNC;
               end
            end
            SYNC, DATA: begin
               if (bitEnd) begin
                  if (stuffPending) begin
                     lineState    <= nrziNext(lineState, 1'b0);
                     onesCount    <= '0;
                     stuffPending <= 1'b0;
                  end else if (bitIdx != 3'd7) begin
                     shiftReg     <= shiftReg >> 1;
                     bitIdx       <= bitIdx + 3'd1;
                     lineState    <= nrziNext(lineState, launchBit);
                     onesCount    <= onesNext;
                     stuffPending <= (onesNext == 3'(STUFF_LIMIT));
                  end else if (state == SYNC) begin
                     shiftReg     <= holdData;
                     bitIdx       <= '0;
                     lineState    <= nrziNext(lineState, launchBit);
                     onesCount    <= onesNext;
                     stuffPending <= (onesNext == 3'(STUFF_LIMIT));
                     state        <= DATA;
                  end else if (!holdLast && tx_valid) begin
                     shiftReg     <= tx_data;
                     holdLast     <= tx_last;
                     bitIdx       <= '0;
                     lineState    <= nrziNext(lineState, launchBit);
                     onesCount    <= onesNext;
                     stuffPending <= (onesNext == 3'(STUFF_LIMIT));
                  end else begin
                     underrunReg  <= !holdLast;
                     lineState    <= SE0;
                     eopCount     <= '0;
                     state        <= EOP_SE0;
                  end
               end
            end
            EOP_SE0: begin
               if (bitEnd) begin
                  if (eopCount == 2'(EOP_SE0_BITS - 1)) begin
                     lineState <= J;
                     state     <= EOP_J;
                  end else begin
                     eopCount <= eopCount + 2'd1;
                  end
               end
            end
            EOP_J: begin
               if (bitEnd) begin
                  txActiveReg <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               lineState <= J;
               state     <= IDLE;
            end
         endcase
      end
   end

   // The pins come straight from registers so the bus driver sees clean edges
   always_comb begin
      dp_out      = lineState[1];
      dm_out      = lineState[0];
      tx_active   = txActiveReg;
      tx_underrun = underrunReg;
   end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for the USB transmit serializer. Each packet is compared
// cycle by cycle against a hand-derived line trace (J, K, S for SE0), plus
// packet length, tx_ready timing and underrun pulses.
module tb_usb_tx_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       dp_out;
   logic       dm_out;
   logic       tx_active;
   logic       tx_underrun;

   int testsRun  = 0;
   int failCount = 0;

   usb_tx_serializer #(
      .CLKS_PER_BIT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .dp_out     (dp_out),
      .dm_out     (dm_out),
      .tx_active  (tx_active),
      .tx_underrun(tx_underrun)
   );

   // 10 ns system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [1:0] lineCode(input byte c);
      if (c == "J") return 2'b10;
      if (c == "K") return 2'b01;
      return 2'b00;
   endfunction

   // Send a one- or two-byte packet and follow it to the end. With
   // lastOnFinal=0 and one byte, tx_valid is dropped to force an underrun.
   task automatic applyStimulus(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                input int nBytes, input logic lastOnFinal, input string expLine,
                                input int expReadyCount, input int expReadyCycle, input int expUnderruns);
      int  cyc;
      int  readyCount;
      int  readyCycle;
      int  underrunCount;
      int  expCycles;
      logic handshake;
      cyc           = 0;
      readyCount    = 0;
      readyCycle    = -1;
      underrunCount = 0;
      expCycles     = expLine.len() * 4;

      @(negedge clk);
      checkOutput({name, " idle ready"}, 32'(tx_ready), 32'd1);
      tx_data  = b0;
      tx_valid = 1'b1;
      tx_last  = (nBytes == 1) ? lastOnFinal : 1'b0;
      @(posedge clk);
      #1;
      if (nBytes > 1) begin
         tx_data = b1;
         tx_last = 1'b1;
      end else begin
         tx_valid = 1'b0;
         tx_data  = 8'h00;
         tx_last  = 1'b0;
      end

      forever begin
         @(negedge clk);
         if (!tx_active) break;
         if (cyc < expCycles) begin
            checkOutput($sformatf("%s line c%0d", name, cyc), 32'({dp_out, dm_out}),
                        32'(lineCode(expLine[cyc / 4])));
         end
         handshake = tx_ready && tx_valid;
         if (tx_ready) begin
            readyCount++;
            readyCycle = cyc;
         end
         if (tx_underrun) underrunCount++;
         cyc++;
         if (cyc > 600) begin
            checkOutput({name, " timeout"}, 32'd0, 32'd1);
            break;
         end
         if (handshake) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            tx_last  = 1'b0;
         end
      end

      checkOutput({name, " active cycles"}, 32'(cyc), 32'(expCycles));
      checkOutput({name, " ready count"}, 32'(readyCount), 32'(expReadyCount));
      checkOutput({name, " ready cycle"}, 32'(readyCycle), 32'(expReadyCycle));
      checkOutput({name, " underruns"}, 32'(underrunCount), 32'(expUnderruns));
      checkOutput({name, " line after"}, 32'({dp_out, dm_out}), 32'(2'b10));
   endtask

   initial begin
      int guard;
      rst      = 1'b1;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Reset asserted while idle
      rst = 1'b1;
      #1;
      checkOutput("idle rst dp", 32'(dp_out), 32'd1);
      checkOutput("idle rst dm", 32'(dm_out), 32'd0);
      checkOutput("idle rst active", 32'(tx_active), 32'd0);
      checkOutput("idle rst ready", 32'(tx_ready), 32'd1);
      checkOutput("idle rst underrun", 32'(tx_underrun), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single 0x00: SYNC then eight toggles then EOP
      applyStimulus("byte00", 8'h00, 8'h00, 1, 1'b1,
                    "KJKJKJKKJKJKJKJKSSJ", 0, -1, 0);

      // 0xFF 0xFF: stuff after byte1 bit 5 and byte2 bit 3
      applyStimulus("ffff", 8'hFF, 8'hFF, 2, 1'b1,
                    "KJKJKJKKKKKKKJJJJJJJKKKKKKSSJ", 1, 67, 0);

      // 0xFC: six trailing ones, stuff toggle precedes SE0
      applyStimulus("fc", 8'hFC, 8'h00, 1, 1'b1,
                    "KJKJKJKKJKKKKKKKJSSJ", 0, -1, 0);

      // 0xA5 with tx_last=0 and no follow-on byte: truncated packet
      applyStimulus("underrun", 8'hA5, 8'h00, 1, 1'b0,
                    "KJKJKJKKKJJKJJKKSSJ", 1, 63, 1);

      // Reset in the middle of byte 2 of a 0xFF, 0x00 packet
      @(negedge clk);
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      tx_last  = 1'b0;
      @(posedge clk);
      #1;
      tx_data = 8'h00;
      tx_last = 1'b1;
      guard   = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!tx_ready && guard < 200);
      checkOutput("rst pkt byte2 fetch", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      repeat (13) @(negedge clk);
      checkOutput("rst pkt active before", 32'(tx_active), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid rst dp", 32'(dp_out), 32'd1);
      checkOutput("mid rst dm", 32'(dm_out), 32'd0);
      checkOutput("mid rst active", 32'(tx_active), 32'd0);
      checkOutput("mid rst ready", 32'(tx_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Following packet must be identical to the clean single-byte trace
      applyStimulus("after rst", 8'h00, 8'h00, 1, 1'b1,
                    "KJKJKJKKJKJKJKJKSSJ", 0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
